fb_swap_controller: RTL
=======================

Name: fb_swap_controller

Overview:
- Sequences a double-buffered pair of framebuffers (buffer 0, buffer 1) for the rasteriser.
- Per frame it clears the back buffer, opens the back buffer's write port to the draw pipeline, waits for draw completion and vertical sync, then swaps front/back.
- Sits between the rasteriser write stream and the two framebuffer write ports.
- Drives front_sel to the display read-side mux.

Parameters:
- FB_WIDTH, 160, framebuffer width in pixels
- FB_HEIGHT, 120, framebuffer height in pixels
- DATA_WIDTH, 4, pixel/depth word width
- FB_SIZE (localparam), FB_WIDTH*FB_HEIGHT
- ADDR_WIDTH (localparam), $clog2(FB_SIZE)

Ports:
- clk  in  1  single system clock; write clock of both framebuffers
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  request to begin a new frame; accepted only when ready=1
- ready  out  1  high in IDLE only
- clear_value  in  DATA_WIDTH  value used to clear the back buffer; sampled on frame_start acceptance
- draw_ready  out  1  high in DRAW only; draw pipeline may write
- draw_we  in  1  draw write strobe
- draw_addr  in  ADDR_WIDTH  draw write address
- draw_data  in  DATA_WIDTH  draw write data
- draw_done  in  1  single-cycle pulse: last write of frame issued
- vsync  in  1  single-cycle pulse, already synchronous to clk
- fb_clear  out  2  per-buffer clear strobe (bit i drives buffer i)
- fb_clear_value  out  DATA_WIDTH  registered copy of clear_value
- fb_we  out  2  per-buffer write enable
- fb_addr  out  ADDR_WIDTH  shared write address (= draw_addr)
- fb_data  out  DATA_WIDTH  shared write data (= draw_data)
- front_sel  out  1  index of buffer being displayed; back = ~front_sel
- frame_done  out  1  one-cycle pulse on swap

Behaviour:
- States: IDLE, CLEAR, DRAW, WAIT_VSYNC, SWAP. Encoding is free.
- Reset values: state=IDLE, front_sel=0, fb_clear=0, fb_we=0, fb_clear_value=0, frame_done=0, clear counter=0.
  - ready=1 out of reset; draw_ready=0.
- IDLE → CLEAR: when frame_start=1.
  - clear_value is latched into fb_clear_value on the same edge.
  - frame_start in any other state is ignored and not queued.
- CLEAR:
  - fb_clear[~front_sel]=1 for exactly FB_SIZE consecutive cycles; the other bit stays 0.
  - Internal counter (ADDR_WIDTH bits) counts 0..FB_SIZE-1.
  - On the cycle the counter = FB_SIZE-1, go to DRAW and reset the counter to 0.
  - Rationale: the framebuffer's internal clear index wraps modulo FB_SIZE. Any FB_SIZE consecutive clear cycles therefore cover every address once, regardless of the index left behind by an earlier interrupted clear.
- DRAW:
  - draw_ready=1.
  - fb_we[~front_sel]=draw_we, combinational pass-through.
  - fb_we[front_sel]=0 always.
  - On draw_done=1 go to WAIT_VSYNC. A draw_we in the same cycle as draw_done is still forwarded.
- Outside DRAW: fb_we=0 and draw_we is dropped. Writes are never forwarded to the front buffer.
- WAIT_VSYNC:
  - Stay until vsync=1, then go to SWAP.
  - A vsync seen in DRAW, including in the same cycle as draw_done, is not counted; the next vsync is required.
- SWAP (one cycle):
  - front_sel toggles at the end of the cycle.
  - frame_done=1 during this cycle.
  - Next state is IDLE.
- Minimum frame latency, frame_start to frame_done: 1 + FB_SIZE + (draw cycles) + (vsync wait) + 1.
- fb_addr and fb_data are continuous pass-throughs of draw_addr and draw_data.
- Reset mid-operation (any state):
  - Returns to IDLE next cycle with all strobes low and front_sel=0.
  - An interrupted clear is redone in full by the next frame.

Optional Feature:
- Macro: FB_CTRL_VSYNC_WAIT_EN.
- Defined: behaviour as above; swap occurs only on vsync (tear-free).
- Undefined:
  - WAIT_VSYNC does not exist; DRAW goes directly to SWAP on draw_done.
  - vsync is unused; the port remains present.
  - Swap happens 1 cycle after draw_done.

Test Plan (FB_WIDTH=4, FB_HEIGHT=4, so FB_SIZE=16):
- Reset, frame_start=1 with clear_value=4'hA:
  - ready falls next cycle.
  - fb_clear=2'b10 for exactly 16 cycles.
  - fb_clear_value=4'hA.
  - Then draw_ready=1.
- In DRAW, draw_we=1, addr=5, data=3: fb_we=2'b10, fb_addr=5, fb_data=3. Write attempts in IDLE and CLEAR give fb_we=2'b00.
- draw_done, then vsync 7 cycles later:
  - frame_done pulses once in the cycle after vsync.
  - front_sel 0→1.
  - Next frame clears with fb_clear=2'b01.
- draw_done and vsync in the same cycle: no swap. The next vsync, 10 cycles later, triggers frame_done. Without FB_CTRL_VSYNC_WAIT_EN, frame_done follows draw_done by 1 cycle.
- rst asserted at clear cycle 9:
  - All outputs return to their reset values.
  - A following frame_start gives a full 16-cycle fb_clear.
- frame_start held high continuously: frames run back-to-back, each restarting from IDLE; none are accepted while ready=0.

Source files
------------

// File: rtl/fb_swap_controller.sv
// fb_swap_controller
//   Sequences a double-buffered framebuffer pair for the rasteriser. For each
//   frame it clears the back buffer, opens the back buffer write port to the
//   draw pipeline, waits for draw completion (and vsync when enabled), then
//   swaps front and back.
//
// Build option:
//   FB_CTRL_VSYNC_WAIT_EN  defined   : swap waits for the next vsync (tear-free)
//                          undefined : swap happens the cycle after draw_done,
//                                      vsync is ignored
//
// Ports:
//   clk, rst           system clock / synchronous active-high reset
//   frame_start, ready frame request handshake (accepted only in IDLE)
//   clear_value        clear word, captured on frame_start acceptance
//   draw_ready         draw pipeline may write (DRAW only)
//   draw_we/addr/data  draw write stream
//   draw_done          last write of frame issued (pulse)
//   vsync              vertical sync pulse, synchronous to clk
//   fb_clear[1:0]      per-buffer clear strobe
//   fb_clear_value     registered clear word
//   fb_we[1:0]         per-buffer write enable
//   fb_addr, fb_data   shared write address/data (pass-through)
//   front_sel          buffer currently displayed; back = ~front_sel
//   frame_done         one-cycle pulse during swap
//
// state      | meaning
// -----------+------------------------------------------------------
// S_IDLE     | waiting for frame_start; ready=1
// S_CLEAR    | back buffer clear strobe held for FB_SIZE cycles
// S_DRAW     | back buffer write port open to the draw pipeline
// S_WAIT_VS  | draw finished, waiting for a fresh vsync (option only)
// S_SWAP     | one cycle; frame_done=1, front_sel toggles at its end

module fb_swap_controller #(
    parameter int  FB_WIDTH   = 160,
    parameter int  FB_HEIGHT  = 120,
    parameter int  DATA_WIDTH = 4,
    localparam int FB_SIZE    = FB_WIDTH * FB_HEIGHT,
    localparam int ADDR_WIDTH = $clog2(FB_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  draw_ready,
    input  logic                  draw_we,
    input  logic [ADDR_WIDTH-1:0] draw_addr,
    input  logic [DATA_WIDTH-1:0] draw_data,
    input  logic                  draw_done,
    input  logic                  vsync,
    output logic [1:0]            fb_clear,
    output logic [DATA_WIDTH-1:0] fb_clear_value,
    output logic [1:0]            fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [DATA_WIDTH-1:0] fb_data,
    output logic                  front_sel,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_DRAW    = 3'd2,
`ifdef FB_CTRL_VSYNC_WAIT_EN
        S_WAIT_VS = 3'd3,
`endif
        S_SWAP    = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  clr_last;
    logic                  back_sel;

`ifndef FB_CTRL_VSYNC_WAIT_EN
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    assign clr_last = (clr_cnt_q == ADDR_WIDTH'(FB_SIZE - 1));
    assign back_sel = ~front_sel;
    assign fb_addr  = draw_addr;
    assign fb_data  = draw_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear counter, clear word capture and front buffer select
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q      <= '0;
            fb_clear_value <= '0;
            front_sel      <= 1'b0;
        end else begin
            if (state_q == S_IDLE && frame_start) begin
                fb_clear_value <= clear_value;
            end
            if (state_q == S_CLEAR) begin
                clr_cnt_q <= clr_last ? '0 : clr_cnt_q + 1'b1;
            end
            if (state_q == S_SWAP) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start) state_d = S_CLEAR;
            S_CLEAR: if (clr_last)    state_d = S_DRAW;
`ifdef FB_CTRL_VSYNC_WAIT_EN
            // A vsync coincident with draw_done is deliberately not taken.
            S_DRAW:    if (draw_done) state_d = S_WAIT_VS;
            S_WAIT_VS: if (vsync)     state_d = S_SWAP;
`else
            S_DRAW:  if (draw_done)   state_d = S_SWAP;
`endif
            S_SWAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ready      = 1'b0;
        draw_ready = 1'b0;
        fb_clear   = 2'b00;
        fb_we      = 2'b00;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_CLEAR: fb_clear[back_sel] = 1'b1;
            S_DRAW: begin
                draw_ready      = 1'b1;
                fb_we[back_sel] = draw_we;
            end
            S_SWAP:  frame_done = 1'b1;
            default: ;
        endcase
    end

endmodule
